// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the CPU run controller: state encoding,
// execution modes, stop causes and a small mode helper.
package cpu_ctrl_pkg;

    // Controller states; the numeric values are visible on state_o
    typedef enum logic [2:0] {
        ST_HOLD    = 3'd0,
        ST_RELEASE = 3'd1,
        ST_IDLE    = 3'd2,
        ST_RUN     = 3'd3,
        ST_STEP    = 3'd4,
        ST_DONE    = 3'd5
    } state_t;

    // Execution modes as presented on the mode input
    localparam logic [1:0] MODE_FREE   = 2'b00;
    localparam logic [1:0] MODE_BUDGET = 2'b01;
    localparam logic [1:0] MODE_STEP   = 2'b10;
    localparam logic [1:0] MODE_RSVD   = 2'b11;

    // Reasons execution stopped, reported while done is high
    localparam logic [1:0] CAUSE_NONE   = 2'b00;
    localparam logic [1:0] CAUSE_HALT   = 2'b01;
    localparam logic [1:0] CAUSE_BUDGET = 2'b10;
    localparam logic [1:0] CAUSE_ABORT  = 2'b11;

    // The reserved mode behaves exactly like free-run
    function automatic logic [1:0] norm_mode(input logic [1:0] m);
        return (m == MODE_RSVD) ? MODE_FREE : m;
    endfunction

endpackage

// File: rtl/cpu_run_ctrl_rst_stagger.sv
// Staggered reset release: a hold counter that runs from 0 up to the
// last domain's release point, with one comparator per reset domain.
// Domain i is held in reset while the count is below
// RESET_CYCLES + i*STAGGER, so bit 0 always releases first.
module rst_stagger
    import cpu_ctrl_pkg::*;
#(
    parameter int N_DOMAINS    = 2,
    parameter int RESET_CYCLES = 2,
    parameter int STAGGER      = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 restart,
    output logic [N_DOMAINS-1:0] cpu_rst,
    output logic                 hold_last,
    output logic                 release_done
);

    localparam int MAX_THR = RESET_CYCLES + (N_DOMAINS - 1) * STAGGER;
    localparam int CW      = $clog2(MAX_THR + 1);

    localparam logic [CW-1:0] MAX_CNT   = CW'(MAX_THR);
    localparam logic [CW-1:0] HOLD_LAST = CW'(RESET_CYCLES - 1);

    logic [CW-1:0] hold_cnt;

    // Hold counter: cleared on restart, then counts up and parks at the
    // final release point so every domain stays released afterwards
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt <= '0;
        end else if (restart) begin
            hold_cnt <= '0;
        end else if (hold_cnt != MAX_CNT) begin
            hold_cnt <= hold_cnt + CW'(1);
        end
    end

    // One release comparator per domain, decoded from the registered count
    for (genvar i = 0; i < N_DOMAINS; i++) begin : g_domain
        localparam logic [CW-1:0] THR = CW'(RESET_CYCLES + i * STAGGER);
        assign cpu_rst[i] = (hold_cnt < THR);
    end

    // Status decodes used by the controller FSM
    assign hold_last    = (hold_cnt == HOLD_LAST);
    assign release_done = (hold_cnt == MAX_CNT);

endmodule

// File: rtl/cpu_run_ctrl.sv
// CPU run controller: sequences staggered reset release, then runs the
// core free, for a cycle budget, or one step at a time, counting enabled
// cycles and recording why execution stopped.
module cpu_run_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int N_DOMAINS    = 2,
    parameter int RESET_CYCLES = 2,
    parameter int STAGGER      = 1,
    parameter int CNT_W        = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [1:0]           mode,
    input  logic [CNT_W-1:0]     budget,
    input  logic                 step,
    input  logic                 halt_req,
    input  logic                 abort,
    output logic [N_DOMAINS-1:0] cpu_rst,
    output logic                 cpu_en,
    output logic [CNT_W-1:0]     cycle_count,
    output logic                 done,
    output logic [1:0]           stop_cause,
    output logic [2:0]           state_o
);

    state_t           state;
    state_t           state_next;
    logic [1:0]       mode_q;
    logic [CNT_W-1:0] budget_q;
    logic             step_grant;
    logic             hold_last;
    logic             release_done;
    logic             restart;
    logic             start_accept;
    logic             cause_load;
    logic [1:0]       cause_in;
    logic [CNT_W-1:0] count_inc;

    assign restart      = (state == ST_DONE) && start;
    assign start_accept = (state == ST_IDLE) && start && !abort;
    assign count_inc    = cycle_count + CNT_W'(1);

    rst_stagger #(
        .N_DOMAINS    (N_DOMAINS),
        .RESET_CYCLES (RESET_CYCLES),
        .STAGGER      (STAGGER)
    ) u_rst_stagger (
        .clk          (clk),
        .rst_n        (rst_n),
        .restart      (restart),
        .cpu_rst      (cpu_rst),
        .hold_last    (hold_last),
        .release_done (release_done)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_HOLD;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic with stop arbitration: abort beats halt beats budget
    always_comb begin
        state_next = state;
        cause_load = 1'b0;
        cause_in   = CAUSE_NONE;
        case (state)
            ST_HOLD: begin
                if (hold_last) begin
                    state_next = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                if (release_done) begin
                    state_next = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (abort) begin
                    state_next = ST_DONE;
                    cause_load = 1'b1;
                    cause_in   = CAUSE_ABORT;
                end else if (start) begin
                    if (norm_mode(mode) == MODE_BUDGET && budget == '0) begin
                        state_next = ST_DONE;
                        cause_load = 1'b1;
                        cause_in   = CAUSE_BUDGET;
                    end else if (norm_mode(mode) == MODE_STEP) begin
                        state_next = ST_STEP;
                    end else begin
                        state_next = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (abort) begin
                    state_next = ST_DONE;
                    cause_load = 1'b1;
                    cause_in   = CAUSE_ABORT;
                end else if (halt_req) begin
                    state_next = ST_DONE;
                    cause_load = 1'b1;
                    cause_in   = CAUSE_HALT;
                end else if (mode_q == MODE_BUDGET && count_inc == budget_q) begin
                    state_next = ST_DONE;
                    cause_load = 1'b1;
                    cause_in   = CAUSE_BUDGET;
                end
            end
            ST_STEP: begin
                if (abort) begin
                    state_next = ST_DONE;
                    cause_load = 1'b1;
                    cause_in   = CAUSE_ABORT;
                end else if (step_grant && halt_req) begin
                    state_next = ST_DONE;
                    cause_load = 1'b1;
                    cause_in   = CAUSE_HALT;
                end
            end
            ST_DONE: begin
                if (start) begin
                    state_next = ST_HOLD;
                end
            end
            default: begin
                state_next = ST_HOLD;
            end
        endcase
    end

    // Outputs decoded purely from registered state
    always_comb begin
        cpu_en  = (state == ST_RUN) || (state == ST_STEP && step_grant);
        done    = (state == ST_DONE);
        state_o = state;
    end

    // Run configuration captured when execution is launched from IDLE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q   <= MODE_FREE;
            budget_q <= '0;
        end else if (start_accept) begin
            mode_q   <= norm_mode(mode);
            budget_q <= budget;
        end
    end

    // Single-step grant: one enabled cycle per step pulse, and pulses that
    // land on an already granted cycle are dropped rather than queued
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step_grant <= 1'b0;
        end else begin
            step_grant <= (state == ST_STEP) && (state_next == ST_STEP)
                          && step && !step_grant;
        end
    end

    // Enabled-cycle counter, cleared on launch and saturating at all-ones
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_count <= '0;
        end else if (start_accept) begin
            cycle_count <= '0;
        end else if (cpu_en && cycle_count != '1) begin
            cycle_count <= count_inc;
        end
    end

    // Stop cause: captured on entry to DONE, cleared on a fresh launch
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stop_cause <= CAUSE_NONE;
        end else if (cause_load) begin
            stop_cause <= cause_in;
        end else if (start_accept) begin
            stop_cause <= CAUSE_NONE;
        end
    end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed testbench for cpu_run_ctrl: a default-parameter instance for
// sequencing, budget, halt, step and abort scenarios, plus a CNT_W=4
// instance for counter saturation.
module tb_cpu_run_ctrl;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [1:0]  mode;
    logic [15:0] budget;
    logic        step;
    logic        halt_req;
    logic        abort;
    logic [1:0]  cpu_rst;
    logic        cpu_en;
    logic [15:0] cycle_count;
    logic        done;
    logic [1:0]  stop_cause;
    logic [2:0]  state_o;

    logic        s_rst_n;
    logic        s_start;
    logic [1:0]  s_mode;
    logic [3:0]  s_budget;
    logic        s_step;
    logic        s_halt_req;
    logic        s_abort;
    logic [1:0]  s_cpu_rst;
    logic        s_cpu_en;
    logic [3:0]  s_cycle_count;
    logic        s_done;
    logic [1:0]  s_stop_cause;
    logic [2:0]  s_state_o;

    int vectors;
    int miscompares;

    cpu_run_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .mode        (mode),
        .budget      (budget),
        .step        (step),
        .halt_req    (halt_req),
        .abort       (abort),
        .cpu_rst     (cpu_rst),
        .cpu_en      (cpu_en),
        .cycle_count (cycle_count),
        .done        (done),
        .stop_cause  (stop_cause),
        .state_o     (state_o)
    );

    cpu_run_ctrl #(.CNT_W(4)) dut4 (
        .clk         (clk),
        .rst_n       (s_rst_n),
        .start       (s_start),
        .mode        (s_mode),
        .budget      (s_budget),
        .step        (s_step),
        .halt_req    (s_halt_req),
        .abort       (s_abort),
        .cpu_rst     (s_cpu_rst),
        .cpu_en      (s_cpu_en),
        .cycle_count (s_cycle_count),
        .done        (s_done),
        .stop_cause  (s_stop_cause),
        .state_o     (s_state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock and settle just after the active edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse start for one cycle with the given run configuration
    task automatic launch(input logic [1:0] m, input logic [15:0] b);
        mode   = m;
        budget = b;
        start  = 1'b1;
        tick();
        start  = 1'b0;
    endtask

    // From DONE, restart and wait out the reset release sequence
    task automatic go_idle();
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        vectors++;
        if (state_o !== 3'd2) begin
            miscompares++;
            $display("[TB] FAIL go_idle_state: got %0d expected 2", state_o);
        end
    endtask

    // Reset values and the staggered release after rst_n rises
    task automatic test_reset();
        logic [1:0] exp_rst [4];
        logic [2:0] exp_st  [4];
        exp_rst = '{2'b11, 2'b10, 2'b00, 2'b00};
        exp_st  = '{3'd0, 3'd1, 3'd1, 3'd2};
        repeat (3) tick();
        vectors++;
        if (cpu_rst !== 2'b11 || cpu_en !== 1'b0 || cycle_count !== 16'd0 ||
            done !== 1'b0 || stop_cause !== 2'b00 || state_o !== 3'd0) begin
            miscompares++;
            $display("[TB] FAIL reset_values: got rst=%b en=%b cnt=%0d done=%b cause=%b st=%0d expected 11 0 0 0 00 0",
                     cpu_rst, cpu_en, cycle_count, done, stop_cause, state_o);
        end
        rst_n   = 1'b1;
        s_rst_n = 1'b1;
        for (int e = 0; e < 4; e++) begin
            tick();
            vectors++;
            if (cpu_rst !== exp_rst[e] || state_o !== exp_st[e] || cpu_en !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL release_edge%0d: got rst=%b st=%0d en=%b expected rst=%b st=%0d en=0",
                         e + 1, cpu_rst, state_o, cpu_en, exp_rst[e], exp_st[e]);
            end
        end
    endtask

    // Budget of 5 gives exactly five enabled cycles
    task automatic test_budget();
        int en_cycles;
        en_cycles = 0;
        launch(2'b01, 16'd5);
        for (int i = 0; i < 10; i++) begin
            if (cpu_en === 1'b1) en_cycles++;
            tick();
        end
        vectors++;
        if (en_cycles != 5) begin
            miscompares++;
            $display("[TB] FAIL budget_en_cycles: got %0d expected 5", en_cycles);
        end
        vectors++;
        if (done !== 1'b1 || stop_cause !== 2'b10 || cycle_count !== 16'd5 || state_o !== 3'd5) begin
            miscompares++;
            $display("[TB] FAIL budget_done: got done=%b cause=%b cnt=%0d st=%0d expected 1 10 5 5",
                     done, stop_cause, cycle_count, state_o);
        end
    endtask

    // Halt on the 8th enabled cycle, optionally coinciding with budget expiry
    task automatic test_halt(input logic [1:0] m, input logic [15:0] b);
        launch(m, b);
        vectors++;
        if (state_o !== 3'd3 || cpu_en !== 1'b1 || stop_cause !== 2'b00) begin
            miscompares++;
            $display("[TB] FAIL halt_run_entry: got st=%0d en=%b cause=%b expected 3 1 00",
                     state_o, cpu_en, stop_cause);
        end
        repeat (7) tick();
        vectors++;
        if (cycle_count !== 16'd7 || cpu_en !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL halt_pre_count: got cnt=%0d en=%b expected 7 1", cycle_count, cpu_en);
        end
        halt_req = 1'b1;
        tick();
        halt_req = 1'b0;
        vectors++;
        if (done !== 1'b1 || stop_cause !== 2'b01 || cycle_count !== 16'd8 || cpu_en !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL halt_mode%0d: got done=%b cause=%b cnt=%0d en=%b expected 1 01 8 0",
                     m, done, stop_cause, cycle_count, cpu_en);
        end
    endtask

    // Single-step: three spaced pulses plus a back-to-back duplicate, then abort
    task automatic test_step();
        logic [11:0] pat;
        int highs;
        int doubles;
        logic prev_en;
        pat     = 12'b0001_0011_0001;
        highs   = 0;
        doubles = 0;
        prev_en = 1'b0;
        launch(2'b10, 16'd0);
        vectors++;
        if (state_o !== 3'd4 || cpu_en !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL step_entry: got st=%0d en=%b expected 4 0", state_o, cpu_en);
        end
        for (int t = 0; t < 12; t++) begin
            step = pat[t];
            tick();
            if (cpu_en === 1'b1) begin
                highs++;
                if (prev_en) doubles++;
            end
            prev_en = cpu_en;
        end
        step = 1'b0;
        vectors++;
        if (highs != 3 || doubles != 0) begin
            miscompares++;
            $display("[TB] FAIL step_pulses: got highs=%0d doubles=%0d expected 3 0", highs, doubles);
        end
        vectors++;
        if (cycle_count !== 16'd3 || state_o !== 3'd4) begin
            miscompares++;
            $display("[TB] FAIL step_count: got cnt=%0d st=%0d expected 3 4", cycle_count, state_o);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        vectors++;
        if (done !== 1'b1 || stop_cause !== 2'b11 || cycle_count !== 16'd3) begin
            miscompares++;
            $display("[TB] FAIL step_abort: got done=%b cause=%b cnt=%0d expected 1 11 3",
                     done, stop_cause, cycle_count);
        end
    endtask

    // Zero budget stops immediately; restart from DONE replays the reset sequence
    task automatic test_budget_zero();
        logic [1:0] exp_rst [5];
        logic [2:0] exp_st  [5];
        exp_rst = '{2'b11, 2'b11, 2'b10, 2'b00, 2'b00};
        exp_st  = '{3'd0, 3'd0, 3'd1, 3'd1, 3'd2};
        launch(2'b01, 16'd0);
        vectors++;
        if (state_o !== 3'd5 || stop_cause !== 2'b10 || cycle_count !== 16'd0 || cpu_en !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL budget_zero: got st=%0d cause=%b cnt=%0d en=%b expected 5 10 0 0",
                     state_o, stop_cause, cycle_count, cpu_en);
        end
        start = 1'b1;
        for (int e = 0; e < 5; e++) begin
            tick();
            start = 1'b0;
            vectors++;
            if (cpu_rst !== exp_rst[e] || state_o !== exp_st[e] || done !== 1'b0 || cpu_en !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL replay_edge%0d: got rst=%b st=%0d done=%b en=%b expected rst=%b st=%0d done=0 en=0",
                         e, cpu_rst, state_o, done, cpu_en, exp_rst[e], exp_st[e]);
            end
        end
    endtask

    // Reserved mode runs like free-run; abort in RUN counts its cycle
    task automatic test_reserved_mode();
        launch(2'b11, 16'd0);
        vectors++;
        if (state_o !== 3'd3 || cpu_en !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL reserved_mode_run: got st=%0d en=%b expected 3 1", state_o, cpu_en);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        vectors++;
        if (stop_cause !== 2'b11 || cycle_count !== 16'd1 || done !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL reserved_mode_abort: got cause=%b cnt=%0d done=%b expected 11 1 1",
                     stop_cause, cycle_count, done);
        end
    endtask

    // Abort while idle goes straight to DONE
    task automatic test_abort_idle();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        vectors++;
        if (state_o !== 3'd5 || stop_cause !== 2'b11 || cpu_en !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL abort_idle: got st=%0d cause=%b en=%b expected 5 11 0",
                     state_o, stop_cause, cpu_en);
        end
    endtask

    // rst_n asserted mid-run clears everything without waiting for an edge
    task automatic test_reset_mid_run();
        launch(2'b00, 16'd0);
        repeat (3) tick();
        vectors++;
        if (cycle_count !== 16'd3 || cpu_en !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL mid_run_pre: got cnt=%0d en=%b expected 3 1", cycle_count, cpu_en);
        end
        rst_n = 1'b0;
        #1;
        vectors++;
        if (cpu_en !== 1'b0 || cpu_rst !== 2'b11 || cycle_count !== 16'd0 || state_o !== 3'd0) begin
            miscompares++;
            $display("[TB] FAIL mid_run_reset: got en=%b rst=%b cnt=%0d st=%0d expected 0 11 0 0",
                     cpu_en, cpu_rst, cycle_count, state_o);
        end
        tick();
        rst_n = 1'b1;
        repeat (4) tick();
        vectors++;
        if (state_o !== 3'd2 || cpu_rst !== 2'b00) begin
            miscompares++;
            $display("[TB] FAIL mid_run_recover: got st=%0d rst=%b expected 2 00", state_o, cpu_rst);
        end
    endtask

    // 4-bit counter saturates at 15 while free-run continues
    task automatic test_saturation();
        s_mode  = 2'b00;
        s_start = 1'b1;
        tick();
        s_start = 1'b0;
        repeat (15) tick();
        vectors++;
        if (s_cycle_count !== 4'd15 || s_cpu_en !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL sat_reach: got cnt=%0d en=%b expected 15 1", s_cycle_count, s_cpu_en);
        end
        repeat (3) tick();
        vectors++;
        if (s_cycle_count !== 4'd15 || s_cpu_en !== 1'b1 || s_state_o !== 3'd3) begin
            miscompares++;
            $display("[TB] FAIL sat_hold: got cnt=%0d en=%b st=%0d expected 15 1 3",
                     s_cycle_count, s_cpu_en, s_state_o);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        start       = 1'b0;
        mode        = 2'b00;
        budget      = 16'd0;
        step        = 1'b0;
        halt_req    = 1'b0;
        abort       = 1'b0;
        s_rst_n     = 1'b0;
        s_start     = 1'b0;
        s_mode      = 2'b00;
        s_budget    = 4'd0;
        s_step      = 1'b0;
        s_halt_req  = 1'b0;
        s_abort     = 1'b0;

        test_reset();
        test_budget();
        go_idle();
        test_halt(2'b00, 16'd0);
        go_idle();
        test_halt(2'b01, 16'd8);
        go_idle();
        test_step();
        go_idle();
        test_budget_zero();
        test_reserved_mode();
        go_idle();
        test_abort_idle();
        go_idle();
        test_reset_mid_run();
        test_saturation();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
